// File: rtl/mod_n_stream_detector.sv
// mod_n_stream_detector
// Multi-channel detector that folds an MSB-first stream of SYM_W-bit symbols
// into a running remainder modulo DIVISOR and flags when the value absorbed so
// far is a multiple of DIVISOR and has contained at least one 1 bit.
// Each channel has its own valid strobe, start-of-frame restart and remainder
// output. All outputs are registered.
//
// Optional feature macro: MOD_DET_STATS_EN
//   defined   -> per-channel saturating hit counter on hit_cnt, cleared by cnt_clr
//   undefined -> hit_cnt is tied to zero, cnt_clr is ignored, no counter flops
module mod_n_stream_detector #(
    parameter int DIVISOR   = 5,
    parameter int SYM_W     = 1,
    parameter int NUM_CH    = 1,
    parameter int HIT_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*SYM_W-1:0]       in_sym,
    input  logic [NUM_CH-1:0]             in_sof,
    output logic [NUM_CH-1:0]             div_out,
    output logic [NUM_CH-1:0]             nonzero_seen,
    output logic [NUM_CH*((DIVISOR <= 2) ? 1 : $clog2(DIVISOR))-1:0] rem_out,
    input  logic [NUM_CH-1:0]             cnt_clr,
    output logic [NUM_CH*HIT_CNT_W-1:0]   hit_cnt
);

    // Remainder width; a divisor of 2 still needs one bit.
    localparam int REM_W = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

    // Divisor at the width of the per-bit working value (one bit wider than
    // the remainder, since the remainder is doubled before reduction).
    localparam logic [REM_W:0] DIV_V = DIVISOR[REM_W:0];

    // Reject parameter sets the datapath is not built for.
    if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
        $error("mod_n_stream_detector: DIVISOR must be in 2..65535");
    end
    if (SYM_W < 1 || SYM_W > 8) begin : g_bad_sym_w
        $error("mod_n_stream_detector: SYM_W must be in 1..8");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("mod_n_stream_detector: NUM_CH must be at least 1");
    end
    if (HIT_CNT_W < 1) begin : g_bad_hit_cnt_w
        $error("mod_n_stream_detector: HIT_CNT_W must be at least 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Fold one symbol into a remainder one bit at a time, MSB first. Each
    // step doubles a value below DIVISOR and adds a bit, so the result is
    // below 2*DIVISOR and a single conditional subtract keeps it reduced.
    // The widest intermediate is REM_W+1 bits, whatever the stream length.
    function automatic logic [REM_W-1:0] fold_sym(input logic [REM_W-1:0] base,
                                                  input logic [SYM_W-1:0] sym);
        logic [REM_W:0] acc;
        acc = {1'b0, base};
        for (int i = SYM_W - 1; i >= 0; i--) begin
            acc = {acc[REM_W-1:0], sym[i]};
            if (acc >= DIV_V) begin
                acc = acc - DIV_V;
            end
        end
        return acc[REM_W-1:0];
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYM_W-1:0] sym;
        logic             sym_nz;
        logic [REM_W-1:0] rem;
        state_t           state;
        logic             div_q;
        logic [REM_W-1:0] nxt_rem;
        state_t           nxt_state;
        logic             nxt_div;

        assign sym    = in_sym[c*SYM_W +: SYM_W];
        assign sym_nz = |sym;

        // A start-of-frame symbol restarts from an empty history.
        assign nxt_rem   = fold_sym(in_sof[c] ? '0 : rem, sym);
        assign nxt_state = (sym_nz || (!in_sof[c] && state == TRACK)) ? TRACK : IDLE;
        assign nxt_div   = (nxt_rem == '0) && (nxt_state == TRACK);

        // Channel FSM: remainder, nonzero-history state and divisibility flag
        // all advance together on every accepted symbol and hold otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                rem   <= '0;
                state <= IDLE;
                div_q <= 1'b0;
            end else if (in_valid[c]) begin
                rem   <= nxt_rem;
                state <= nxt_state;
                div_q <= nxt_div;
            end
        end

        assign div_out[c]                  = div_q;
        assign nonzero_seen[c]             = (state == TRACK);
        assign rem_out[c*REM_W +: REM_W]   = rem;

`ifdef MOD_DET_STATS_EN
        logic [HIT_CNT_W-1:0] hits;

        // Saturating hit counter; a clear request beats a same-cycle hit and
        // a start-of-frame does not touch it.
        always_ff @(posedge clk) begin
            if (rst) begin
                hits <= '0;
            end else if (cnt_clr[c]) begin
                hits <= '0;
            end else if (in_valid[c] && nxt_div && (hits != {HIT_CNT_W{1'b1}})) begin
                hits <= hits + 1'b1;
            end
        end

        assign hit_cnt[c*HIT_CNT_W +: HIT_CNT_W] = hits;
`else
        logic unused_cnt_clr;

        assign hit_cnt[c*HIT_CNT_W +: HIT_CNT_W] = '0;
        assign unused_cnt_clr                    = cnt_clr[c];
`endif
    end

endmodule

// File: tb/tb_mod_n_stream_detector.sv
// tb_mod_n_stream_detector
// Directed and randomised stimulus for a three-channel, radix-4, mod-5
// detector. Expected values come from an arithmetic model of the stream value
// modulo DIVISOR kept per channel inside the bench.
module tb_mod_n_stream_detector;

    localparam int DIVISOR   = 5;
    localparam int SYM_W     = 2;
    localparam int NUM_CH    = 3;
    localparam int HIT_CNT_W = 2;
    localparam int REM_W     = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);
    localparam int SYM_BITS  = NUM_CH * SYM_W;
    localparam int RADIX     = 1 << SYM_W;
    localparam int HIT_MAX   = (1 << HIT_CNT_W) - 1;

    logic                        clk;
    logic                        rst;
    logic [NUM_CH-1:0]           in_valid;
    logic [SYM_BITS-1:0]         in_sym;
    logic [NUM_CH-1:0]           in_sof;
    logic [NUM_CH-1:0]           div_out;
    logic [NUM_CH-1:0]           nonzero_seen;
    logic [NUM_CH*REM_W-1:0]     rem_out;
    logic [NUM_CH-1:0]           cnt_clr;
    logic [NUM_CH*HIT_CNT_W-1:0] hit_cnt;

    int testsRun;
    int failCount;

    // Reference model: stream value modulo DIVISOR, whether a 1 bit has been
    // seen, and the number of hits (only when statistics are built in).
    int mRem  [NUM_CH];
    bit mNz   [NUM_CH];
    int mHits [NUM_CH];

    mod_n_stream_detector #(
        .DIVISOR   (DIVISOR),
        .SYM_W     (SYM_W),
        .NUM_CH    (NUM_CH),
        .HIT_CNT_W (HIT_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sym       (in_sym),
        .in_sof       (in_sof),
        .div_out      (div_out),
        .nonzero_seen (nonzero_seen),
        .rem_out      (rem_out),
        .cnt_clr      (cnt_clr),
        .hit_cnt      (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SYM_BITS-1:0] packSym(input int s0, input int s1, input int s2);
        logic [SYM_BITS-1:0] p;
        logic [31:0] t0, t1, t2;
        t0 = s0;
        t1 = s1;
        t2 = s2;
        p = {t2[SYM_W-1:0], t1[SYM_W-1:0], t0[SYM_W-1:0]};
        return p;
    endfunction

    task automatic applyStimulus(input logic [NUM_CH-1:0]   v,
                                 input logic [SYM_BITS-1:0] s,
                                 input logic [NUM_CH-1:0]   sof,
                                 input logic [NUM_CH-1:0]   clr,
                                 input logic                r);
        in_valid = v;
        in_sym   = s;
        in_sof   = sof;
        cnt_clr  = clr;
        rst      = r;
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            int  symv;
            bit  hit;
            hit  = 1'b0;
            symv = int'(s[c*SYM_W +: SYM_W]);
            if (r) begin
                mRem[c]  = 0;
                mNz[c]   = 1'b0;
                mHits[c] = 0;
            end else begin
                if (v[c]) begin
                    if (sof[c]) begin
                        mRem[c] = symv % DIVISOR;
                        mNz[c]  = (symv != 0);
                    end else begin
                        mRem[c] = (mRem[c] * RADIX + symv) % DIVISOR;
                        mNz[c]  = mNz[c] || (symv != 0);
                    end
                    hit = (mRem[c] == 0) && mNz[c];
                end
`ifdef MOD_DET_STATS_EN
                if (clr[c]) begin
                    mHits[c] = 0;
                end else if (hit && mHits[c] < HIT_MAX) begin
                    mHits[c] = mHits[c] + 1;
                end
`else
                mHits[c] = 0;
`endif
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            logic expDiv;
            int   gotRem;
            int   gotHits;
            expDiv  = (mRem[c] == 0) && mNz[c];
            gotRem  = int'(rem_out[c*REM_W +: REM_W]);
            gotHits = int'(hit_cnt[c*HIT_CNT_W +: HIT_CNT_W]);

            testsRun++;
            assert (div_out[c] === expDiv) else begin
                failCount++;
                $error("[TB] FAIL %s ch%0d div_out: got %0b expected %0b", tag, c, div_out[c], expDiv);
            end

            testsRun++;
            assert (nonzero_seen[c] === mNz[c]) else begin
                failCount++;
                $error("[TB] FAIL %s ch%0d nonzero_seen: got %0b expected %0b", tag, c, nonzero_seen[c], mNz[c]);
            end

            testsRun++;
            assert (gotRem === mRem[c]) else begin
                failCount++;
                $error("[TB] FAIL %s ch%0d rem_out: got %0d expected %0d", tag, c, gotRem, mRem[c]);
            end

            testsRun++;
            assert (gotHits === mHits[c]) else begin
                failCount++;
                $error("[TB] FAIL %s ch%0d hit_cnt: got %0d expected %0d", tag, c, gotHits, mHits[c]);
            end
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [NUM_CH-1:0]   v;
        logic [SYM_BITS-1:0] s;
        logic [NUM_CH-1:0]   sof;
        logic [NUM_CH-1:0]   clr;
        logic                r;

        testsRun  = 0;
        failCount = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mRem[c]  = 0;
            mNz[c]   = 1'b0;
            mHits[c] = 0;
        end
        in_valid = '0;
        in_sym   = '0;
        in_sof   = '0;
        cnt_clr  = '0;
        rst      = 1'b1;
        #1;

        // Reset state.
        applyStimulus('0, '0, '0, '0, 1'b1);
        applyStimulus('1, packSym(3, 3, 3), '0, '0, 1'b1);
        checkOutput("reset");

        // ch0 values 1 then 5 (hit); ch1 leading zeros; ch2 value 3 then 14.
        applyStimulus(3'b111, packSym(1, 0, 3), '0, '0, 1'b0);
        checkOutput("first_sym");
        applyStimulus(3'b111, packSym(1, 0, 2), '0, '0, 1'b0);
        checkOutput("second_sym");

        // Gap: valid low holds every channel, SOF ignored while not valid.
        applyStimulus(3'b000, packSym(3, 3, 3), 3'b111, '0, 1'b0);
        checkOutput("gap1");
        applyStimulus(3'b000, packSym(2, 1, 1), 3'b000, '0, 1'b0);
        checkOutput("gap2");

        // ch0 keeps feeding zeros: every cycle is a hit, counter saturates.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b001, packSym(0, 0, 0), '0, '0, 1'b0);
            checkOutput("zero_hits");
        end

        // Clear on a hit cycle wins over the hit.
        applyStimulus(3'b001, packSym(0, 0, 0), '0, 3'b001, 1'b0);
        checkOutput("clear_on_hit");
        applyStimulus(3'b001, packSym(0, 0, 0), '0, 3'b000, 1'b0);
        checkOutput("count_after_clear");

        // ch1 finally sees a 1; ch2 restarts with SOF, ch0 SOF with zero symbol.
        applyStimulus(3'b111, packSym(0, 1, 1), 3'b101, '0, 1'b0);
        checkOutput("sof_restart");
        applyStimulus(3'b111, packSym(1, 1, 1), 3'b000, '0, 1'b0);
        checkOutput("after_sof");

        // SOF does not clear the hit counter: ch2 SOF with 0 after hits.
        applyStimulus(3'b100, packSym(0, 0, 0), 3'b100, '0, 1'b0);
        checkOutput("sof_zero");

        // Reset mid-stream with valid high: symbol is dropped.
        applyStimulus(3'b111, packSym(3, 2, 1), 3'b000, '0, 1'b1);
        checkOutput("mid_reset");
        applyStimulus(3'b111, packSym(1, 2, 3), 3'b000, '0, 1'b0);
        checkOutput("post_reset");

        // Randomised traffic with occasional SOF, clear and reset.
        for (int k = 0; k < 400; k++) begin
            rv  = $urandom;
            v   = rv[NUM_CH-1:0];
            s   = rv[8 +: SYM_BITS];
            rv  = $urandom;
            sof = (rv[3:0] == 4'd0) ? rv[8 +: NUM_CH] : '0;
            clr = (rv[7:4] == 4'd0) ? rv[12 +: NUM_CH] : '0;
            r   = (rv[21:16] == 6'd0);
            applyStimulus(v, s, sof, clr, r);
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
